// File: rtl/disp_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display path.
// Segment vectors are {dp,g,f,e,d,c,b,a}, active-high inside the design;
// pin polarity is applied only at the display_scan_ctrl outputs.
package disp_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam int SEG_DP_BIT = 7;

  // Standard hex glyphs on gfedcba, active-high, dp bit clear.
  localparam seg_t HEX_GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F,   // 0 1 2 3
    8'h66, 8'h6D, 8'h7D, 8'h07,   // 4 5 6 7
    8'h7F, 8'h6F, 8'h77, 8'h7C,   // 8 9 A b
    8'h39, 8'h5E, 8'h79, 8'h71    // C d E F
  };

  // Glyph lookup for one nibble (dp bit always clear).
  function automatic seg_t glyph_of(input nibble_t n);
    return HEX_GLYPH[n];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-high output.
// Blank wins over both the glyph and the decimal point.
module seg7_hex_decode
  import disp_pkg::*;
(
  input  nibble_t i_nibble,
  input  logic    i_dp,
  input  logic    i_blank,
  output seg_t    o_seg
);

  // Glyph plus decimal point, or fully dark when blanked.
  always_comb begin
    o_seg = '0;
    if (!i_blank) begin
      o_seg             = glyph_of(i_nibble);
      o_seg[SEG_DP_BIT] = i_dp;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
//  - Prescaler counts 0..SCAN_DIV-1 per digit slot; count 0 is an anti-ghost
//    dead cycle with all anodes and segments off.
//  - Digit index advances on each prescaler wrap; its wrap ends the frame.
//  - New images are taken through a load handshake into a pending buffer and
//    only promoted to the displayed (active) image at frame end, so a frame
//    never shows a mix of two images.
//  - seg/an are registered (one cycle behind the prescaler/index state).
//  - Optional feature macro DISP_BLINK_EN: a frame counter toggles a blink
//    phase every BLINK_FRAMES frames; in the off phase digits whose
//    blink_mask bit is set are dark while anodes keep sequencing. Without the
//    macro blink_mask is still captured but has no visible effect.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // XOR masks that turn active-high internal values into pin levels.
  localparam seg_t                  SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (SEG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  // Elaboration-time guard on the parameter ranges this block supports.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("display_scan_ctrl: NUM_DIGITS must be in 1..16");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("display_scan_ctrl: SCAN_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("display_scan_ctrl: BLINK_FRAMES must be >= 1");
  end

  // Scan position
  logic [PRESC_W-1:0] r_presc;
  logic [IDX_W-1:0]   r_idx;

  // Pending (accepted, not yet shown) and active (being shown) images
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_pend_digits;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic [NUM_DIGITS-1:0]   r_pend_blink;
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;
  logic [NUM_DIGITS-1:0]   r_act_blink;

  // Registered pin drivers
  seg_t                  r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_frame_end;
  logic                  w_load_fire;
  logic                  w_dead;
  logic                  w_blink_off;
  logic                  w_blank;
  nibble_t               w_nibble;
  seg_t                  w_seg_dec;
  seg_t                  w_seg_lit;
  logic [NUM_DIGITS-1:0] w_an_hot;

  assign w_dead      = (r_presc == '0);
  assign w_frame_end = (r_presc == PRESC_LAST) && (r_idx == IDX_LAST);

  // Handshake: an image transfers on any rising edge where load_valid and
  // load_ready are both high. load_ready is low exactly while an accepted
  // image waits for the frame end; load_valid seen while load_ready is low is
  // dropped and the producer is expected to offer again later.
  assign w_load_fire = load_valid && !r_pend_valid;
  assign load_ready  = !r_pend_valid;
  assign frame_tick  = w_frame_end;

  // Prescaler and digit index; index moves on each prescaler wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Capture offered image into pending; promote pending to active at frame end.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_pend_blink  <= '0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
      r_act_blank   <= '0;
      r_act_blink   <= '0;
    end else begin
      // Promotion needs a pending image, capture needs none, so the two
      // never fire together; an image taken on the frame-end cycle waits a
      // full frame.
      if (w_frame_end && r_pend_valid) begin
        r_act_digits <= r_pend_digits;
        r_act_dp     <= r_pend_dp;
        r_act_blank  <= r_pend_blank;
        r_act_blink  <= r_pend_blink;
        r_pend_valid <= 1'b0;
      end
      if (w_load_fire) begin
        r_pend_digits <= digits;
        r_pend_dp     <= dp_mask;
        r_pend_blank  <= blank_mask;
        r_pend_blink  <= blink_mask;
        r_pend_valid  <= 1'b1;
      end
    end
  end

`ifdef DISP_BLINK_EN
  localparam int                 FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_blink_on;

  // Count frames; flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRAME_LAST) begin
        r_frame_cnt <= '0;
        r_blink_on  <= !r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = !r_blink_on;
`else
  // No blink counter: the phase is permanently on.
  assign w_blink_off = 1'b0;
`endif

  // Current digit's fields from the active image.
  assign w_nibble = r_act_digits[{r_idx, 2'b00} +: 4];
  assign w_blank  = r_act_blank[r_idx] | (w_blink_off & r_act_blink[r_idx]);

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .i_dp     (r_act_dp[r_idx]),
    .i_blank  (w_blank),
    .o_seg    (w_seg_dec)
  );

  assign w_seg_lit = w_dead ? '0 : w_seg_dec;
  assign w_an_hot  = w_dead ? '0 : (NUM_DIGITS'(1) << r_idx);

  // Register pin values, polarity applied last.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_seg <= SEG_POL;
      r_an  <= AN_POL;
    end else begin
      r_seg <= w_seg_lit ^ SEG_POL;
      r_an  <= w_an_hot ^ AN_POL;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=4, active-low pins,
// BLINK_FRAMES=2. Compile with or without DISP_BLINK_EN, same as the RTL.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;
  localparam int SN = N * S;

`ifdef DISP_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } img_t;

  typedef struct packed {
    img_t           img;
    logic [3:0][7:0] exp;   // expected pin value per digit, exp[0] = rightmost
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        load_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clock = ~clock;

  display_scan_ctrl #(
    .NUM_DIGITS     (N),
    .SCAN_DIV       (S),
    .SEG_ACTIVE_LOW (1),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycle position since reset plus the active image and a
  // one-deep queue of accepted-but-not-shown images.
  int          m_t;
  img_t        m_active;
  img_t        exp_q[$];
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_ft;
  logic        exp_ready;
  int          m_slot;
  int          m_digit;
  logic [7:0]  glyph [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] seg_of(input img_t im, input int d, input bit phase_on);
    logic [7:0] g;
    if (im.blank[d] || (im.blink[d] && !phase_on)) return 8'hFF;
    g    = glyph[im.digits[d*4 +: 4]];
    g[7] = im.dp[d];
    return ~g;
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_edge();
    int  p;
    bit  fire;
    bit  phase_on;
    if (!reset) begin
      m_t       = 0;
      m_active  = '0;
      exp_q.delete();
      exp_seg   = 8'hFF;
      exp_an    = 4'hF;
      exp_ft    = 1'b0;
      exp_ready = 1'b1;
      m_slot    = 0;
      m_digit   = 0;
    end else begin
      p        = m_t;
      m_slot   = p % S;
      m_digit  = (p / S) % N;
      phase_on = BLINK_BUILD ? (((p / SN) / BF) % 2 == 0) : 1'b1;
      if (m_slot == 0) begin
        exp_seg = 8'hFF;
        exp_an  = 4'hF;
      end else begin
        exp_an  = ~(4'b0001 << m_digit);
        exp_seg = seg_of(m_active, m_digit, phase_on);
      end
      fire = load_valid && (exp_q.size() == 0);
      if ((p % SN == SN - 1) && exp_q.size() > 0) m_active = exp_q.pop_front();
      if (fire) exp_q.push_back('{digits: digits, dp: dp_mask, blank: blank_mask, blink: blink_mask});
      m_t       = p + 1;
      exp_ft    = (m_t % SN == SN - 1);
      exp_ready = (exp_q.size() == 0);
    end
  endtask

  // One clock: predict, clock, then compare every output 1 time unit later.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("seg", {24'b0, seg}, {24'b0, exp_seg});
    chk("an", {28'b0, an}, {28'b0, exp_an});
    chk("frame_tick", {31'b0, frame_tick}, {31'b0, exp_ft});
    chk("load_ready", {31'b0, load_ready}, {31'b0, exp_ready});
  endtask

  task automatic wait_ft();
    int i;
    i = 0;
    while (!exp_ft && i < 4 * SN) begin
      step();
      i++;
    end
    if (!exp_ft) begin
      n_total++;
      $display("FAIL wait_frame_tick: no frame end within %0d cycles", 4 * SN);
    end
  endtask

  task automatic drive_img(input img_t im);
    digits     = im.digits;
    dp_mask    = im.dp;
    blank_mask = im.blank;
    blink_mask = im.blink;
  endtask

  // Offer an image until it is taken (bounded).
  task automatic load_img(input img_t im);
    bit ok;
    bit will_fire;
    ok = 1'b0;
    drive_img(im);
    load_valid = 1'b1;
    for (int i = 0; i < 4 * SN && !ok; i++) begin
      will_fire = (exp_q.size() == 0);
      step();
      if (will_fire) ok = 1'b1;
    end
    load_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL load_timeout: image %0h not accepted", im.digits);
    end
  endtask

  // Count lit-slot cycles of digit 0 that are dark over one frame.
  task automatic count_dark0(output int dark);
    dark = 0;
    for (int i = 0; i < SN; i++) begin
      step();
      if (m_slot != 0 && m_digit == 0 && seg == 8'hFF) dark++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t tbl [6];
    int   dark;

    glyph = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    tbl[0] = '{img: '{digits: 16'h1234, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000},
               exp: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    tbl[1] = '{img: '{digits: 16'hAAAA, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000},
               exp: {8'h88, 8'h88, 8'h88, 8'h88}};
    tbl[2] = '{img: '{digits: 16'h5555, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000},
               exp: {8'h92, 8'h92, 8'h92, 8'h92}};
    tbl[3] = '{img: '{digits: 16'h1234, dp: 4'b0010, blank: 4'b1000, blink: 4'b0000},
               exp: {8'hFF, 8'hA4, 8'h30, 8'h99}};
    tbl[4] = '{img: '{digits: 16'h0F8E, dp: 4'b1111, blank: 4'b0000, blink: 4'b0000},
               exp: {8'h40, 8'h0E, 8'h00, 8'h06}};
    tbl[5] = '{img: '{digits: 16'hBCD9, dp: 4'b0000, blank: 4'b0101, blink: 4'b0000},
               exp: {8'h83, 8'hFF, 8'hA1, 8'hFF}};

    // Reset held 3 cycles, then the first dead cycle and first lit digit.
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("first_dead_an", {28'b0, an}, 32'hF);
    step();
    chk("first_lit_an", {28'b0, an}, 32'hE);

    // Table: each image shown for one full frame after it becomes active.
    for (int r = 0; r < 6; r++) begin
      load_img(tbl[r].img);
      wait_ft();
      step();
      for (int i = 0; i < SN; i++) begin
        step();
        if (m_slot != 0) chk("tbl_seg", {24'b0, seg}, {24'b0, tbl[r].exp[m_digit]});
      end
    end

    // Mid-frame load must not tear the frame being shown; a second offer
    // while busy is ignored.
    load_img(tbl[0].img);
    wait_ft();
    step();
    repeat (5) step();
    drive_img(tbl[1].img);
    load_valid = 1'b1;
    step();
    chk("ready_drop", {31'b0, load_ready}, 32'h0);
    digits = 16'hFFFF;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4 * SN && !exp_ft; i++) begin
      step();
      if (m_slot != 0) chk("old_frame", {24'b0, seg}, {24'b0, tbl[0].exp[m_digit]});
    end
    step();
    for (int i = 0; i < SN; i++) begin
      step();
      if (m_slot != 0) chk("new_frame", {24'b0, seg}, {24'b0, tbl[1].exp[m_digit]});
    end
    chk("ready_back", {31'b0, load_ready}, 32'h1);

    // Load accepted on the frame_tick cycle waits a whole frame.
    wait_ft();
    drive_img(tbl[2].img);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("ft_load_pending", {31'b0, load_ready}, 32'h0);
    for (int i = 0; i < SN; i++) begin
      step();
      if (m_slot != 0) chk("not_immediate", {24'b0, seg}, {24'b0, tbl[1].exp[m_digit]});
    end
    for (int i = 0; i < SN; i++) begin
      step();
      if (m_slot != 0) chk("next_frame_apply", {24'b0, seg}, {24'b0, tbl[2].exp[m_digit]});
    end

    // Blink on digit 0; the second pass resets in the middle of the off phase.
    for (int rep = 0; rep < 2; rep++) begin
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      load_img('{digits: 16'h1234, dp: 4'b0000, blank: 4'b0000, blink: 4'b0001});
      wait_ft();
      step();
      count_dark0(dark);
      chk("blink_on_after_reset", dark, 0);
      count_dark0(dark);
      chk("blink_off_phase", dark, BLINK_BUILD ? 3 : 0);
    end
    count_dark0(dark);
    chk("blink_off_phase2", dark, BLINK_BUILD ? 3 : 0);
    count_dark0(dark);
    chk("blink_on_again", dark, 0);

    // Randomized traffic, including offers while busy and occasional resets.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end
      load_valid = ($urandom_range(0, 3) == 0);
      digits     = 16'($urandom);
      dp_mask    = 4'($urandom);
      blank_mask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      blink_mask = 4'($urandom);
      step();
    end
    load_valid = 1'b0;
    repeat (2 * SN) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
